ram_arbiter: RTL
================

# ram_arbiter

Single-clock controller that shares one dual-port `RAM` instance (registered read, one write port, one read port) between `NUM_REQ` requesters using round-robin arbitration. After every reset it clears the whole memory to zero, then issues at most one granted command (read or write) per cycle to the RAM. Read data is routed back to the originating requester. It sits between the requester blocks and the RAM; both RAM clocks are tied to `clk` at the parent level.

## Interface

**Parameters**
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WID`, 16: RAM word width.
- `ADDRESS_WID`, 4: RAM address width.
- `ADDRESS_MAX`, 16: number of RAM words, ≤ 2^ADDRESS_WID.

**Ports**
- `clk`, input, 1: single clock. RAM `clk_write` and `clk_read` are driven from it.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, NUM_REQ: per-requester request. Held with its command until granted.
- `we`, input, NUM_REQ: per-requester command type; 1 = write, 0 = read.
- `addr`, input, NUM_REQ*ADDRESS_WID: flattened addresses; requester i uses slice i.
- `wdata`, input, NUM_REQ*DATA_WID: flattened write data.
- `gnt`, output, NUM_REQ: one-hot or zero; command accepted this cycle.
- `rvalid`, output, NUM_REQ: one-hot or zero; `rdata` belongs to this requester.
- `rdata`, output, DATA_WID: shared read-return data.
- `init_done`, output, 1: memory clear finished; arbitration enabled.
- `ram_address_write`, output, ADDRESS_WID: to RAM `address_write`.
- `ram_data_write`, output, DATA_WID: to RAM `data_write`.
- `ram_write_enable`, output, 1: to RAM `write_enable`.
- `ram_address_read`, output, ADDRESS_WID: to RAM `address_read`.
- `ram_data_read`, input, DATA_WID: from RAM `data_read`.

## Operation

**FSM states:** INIT, RUN.
- `rst` forces INIT and `init_cnt`=0.
- INIT → RUN after the write of address ADDRESS_MAX-1 is issued.
- RUN is held until `rst`.

**INIT**
- Each cycle, a registered write command is issued: address `init_cnt`, data 0.
- `init_cnt` then increments.
- `gnt` = 0 throughout.

**RUN arbitration** (combinational in cycle t)
- Scan from `ptr` upward, wrapping modulo NUM_REQ. The first requester with `req` high gets `gnt[i]`=1.
- On a grant, `ptr` ← (i+1) mod NUM_REQ.
- With no request, `ptr` is unchanged and no command is issued.
- Handshake: a request is consumed only in a cycle where `gnt[i]`=1. The requester may change `addr`/`we`/`wdata` or drop `req` the next cycle.

**Command register** (loaded at end of t)
- Granted write: `ram_write_enable`=1, `ram_address_write`=addr_i, `ram_data_write`=wdata_i.
- Granted read: `ram_write_enable`=0, `ram_address_read`=addr_i.
- No grant: `ram_write_enable`=0; address and data registers hold their values.

**Read return pipeline:** 2-stage shift of {valid, requester id}. When stage 2 is valid, the controller drives `rvalid[id]`=1 and `rdata`=`ram_data_read`.

**Hazards:** only one command is issued per cycle. A read granted the cycle after a write to the same address returns the new data, because the write commits one cycle before the read samples memory.

**Reset mid-operation:**
- In-flight reads are discarded and `rvalid` returns to 0.
- The FSM restarts INIT and the memory is cleared again.

## Timing

**Reset values:**
- `gnt`=0, `rvalid`=0, `rdata`=0, `init_done`=0.
- `ram_write_enable`=0, `ram_address_write`=0, `ram_address_read`=0, `ram_data_write`=0.
- `ptr`=0, `init_cnt`=0.

**INIT timing:**
- Cycle k after `rst` falls (k = 0..ADDRESS_MAX-1): the command register loads write(k, 0).
- `init_done` rises registered in cycle ADDRESS_MAX.
- The first grant is possible in cycle ADDRESS_MAX.

**Write timing:** granted in t, presented to the RAM in t+1, committed at the end of t+1.

**Read timing:** granted in t, `rvalid`/`rdata` in t+2. Fixed latency of 2.

**Throughput:** one command per cycle. A continuously requesting requester gets at most 1 grant per NUM_REQ cycles when all requesters are requesting.

## Structure

**Shared package:**
- Command type constants CMD_READ=0 and CMD_WRITE=1.
- FSM state encoding: INIT, RUN.

**Sub-module `rr_arbiter`:**
- Parameter NUM_REQ. Inputs `clk`, `rst`, `req`, `enable`. Output one-hot `gnt`.
- Owns `ptr` and its update.
- Instantiated once, with `enable` = `init_done`.

**Top level:** FSM, command register, and read-return pipeline. The RAM itself is instantiated by the parent, not inside this block.

## Test plan

- **Reset and clear:** pulse `rst` for 2 cycles, then release → 16 consecutive writes addr 0..15 data 0. `init_done`=1 at cycle 16. A read of addr 7 then returns 0x0000.
- **Single requester:** req0 writes 0xBEEF to addr 3 in cycle t; req0 reads addr 3 in cycle t+1 → `rvalid`=4'b0001, `rdata`=0xBEEF in cycle t+3.
- **Full contention:** all four `req` held high for 8 cycles starting with `ptr`=0 → `gnt` sequence 1,2,4,8,1,2,4,8.
- **Pointer skip:** `ptr`=1, `req`=4'b0101 → `gnt`=4'b0100, then `gnt`=4'b0001 next cycle, then `ptr`=1.
- **Cross-requester write-then-read:** req1 writes 0x1234 to addr 9 in cycle t; req2 reads addr 9 in cycle t+1 → `rvalid`=4'b0100, `rdata`=0x1234 in cycle t+3.
- **Reset with reads in flight:** assert `rst` in the cycle after two read grants → no `rvalid` ever asserted for them. INIT restarts and `init_done` is 0 until ADDRESS_MAX cycles after release.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: command encoding and controller state.
package ram_arbiter_pkg;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/ram_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans upward from ptr, grants the first active request,
// then moves ptr just past the winner.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               enable,
   output logic [NUM_REQ-1:0] gnt
);

   localparam int IW = $clog2(NUM_REQ);
   localparam logic [IW:0]   NUM_W = (IW+1)'(NUM_REQ);
   localparam logic [IW-1:0] LAST  = IW'(NUM_REQ - 1);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW:0]   sum;
   logic [IW-1:0] cand;
   logic          found;

   // Grants are suppressed while rst is high so no requester believes a
   // command was accepted in a cycle whose command register is being cleared.
   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr_q} + (IW+1)'(k);
         if (sum >= NUM_W) begin
            sum = sum - NUM_W;
         end
         cand = sum[IW-1:0];
         if (enable && !rst && !found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            ptr_d     = (cand == LAST) ? '0 : cand + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one registered-read dual-port RAM between NUM_REQ requesters: clears
// the memory after reset, then issues one round-robin granted command per cycle.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WID    = 16,
   parameter int ADDRESS_WID = 4,
   parameter int ADDRESS_MAX = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0]             we,
   input  logic [NUM_REQ*ADDRESS_WID-1:0] addr,
   input  logic [NUM_REQ*DATA_WID-1:0]    wdata,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [NUM_REQ-1:0]             rvalid,
   output logic [DATA_WID-1:0]            rdata,
   output logic                           init_done,
   output logic [ADDRESS_WID-1:0]         ram_address_write,
   output logic [DATA_WID-1:0]            ram_data_write,
   output logic                           ram_write_enable,
   output logic [ADDRESS_WID-1:0]         ram_address_read,
   input  logic [DATA_WID-1:0]            ram_data_read,
   output state_e                         dbg_state_o
);

   localparam int IW = $clog2(NUM_REQ);
   localparam logic [ADDRESS_WID-1:0] LAST_ADDR = ADDRESS_WID'(ADDRESS_MAX - 1);

   // Handshake: a requester raises req with we/addr/wdata stable and holds them
   // until it sees gnt[i]=1 in the same cycle; that cycle consumes the command
   // and the requester may change or drop it from the next cycle on. Read data
   // comes back exactly two cycles after the grant, flagged by rvalid[i].

   state_e                 state_q, state_d;
   logic [ADDRESS_WID-1:0] init_cnt_q, init_cnt_d;
   logic                   we_q, we_d;
   logic [ADDRESS_WID-1:0] waddr_q, waddr_d;
   logic [ADDRESS_WID-1:0] raddr_q, raddr_d;
   logic [DATA_WID-1:0]    wdata_q, wdata_d;
   logic                   s1_valid_q, s1_valid_d, s2_valid_q;
   logic [IW-1:0]          s1_id_q, s1_id_d, s2_id_q;

   logic [NUM_REQ-1:0]     arb_gnt;
   logic                   gnt_any;
   logic [IW-1:0]          gnt_idx;
   logic [ADDRESS_WID-1:0] addr_arr  [NUM_REQ];
   logic [DATA_WID-1:0]    wdata_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr[gi*ADDRESS_WID +: ADDRESS_WID];
      assign wdata_arr[gi] = wdata[gi*DATA_WID +: DATA_WID];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .enable (init_done),
      .gnt    (arb_gnt)
   );

   always_comb begin
      gnt_any = |arb_gnt;
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) begin
            gnt_idx = IW'(i);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      raddr_d    = raddr_q;
      s1_valid_d = 1'b0;
      s1_id_d    = '0;
      case (state_q)
         ST_INIT: begin
            we_d       = 1'b1;
            waddr_d    = init_cnt_q;
            wdata_d    = '0;
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_ADDR) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (gnt_any) begin
               if (we[gnt_idx] == CMD_WRITE) begin
                  we_d    = 1'b1;
                  waddr_d = addr_arr[gnt_idx];
                  wdata_d = wdata_arr[gnt_idx];
               end else begin
                  raddr_d    = addr_arr[gnt_idx];
                  s1_valid_d = 1'b1;
                  s1_id_d    = gnt_idx;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         raddr_q    <= '0;
         s1_valid_q <= 1'b0;
         s1_id_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_id_q    <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         raddr_q    <= raddr_d;
         s1_valid_q <= s1_valid_d;
         s1_id_q    <= s1_id_d;
         s2_valid_q <= s1_valid_q;
         s2_id_q    <= s1_id_q;
      end
   end

   // Returns are masked during rst so reads in flight never surface.
   always_comb begin
      rvalid = '0;
      rdata  = '0;
      if (s2_valid_q && !rst) begin
         rvalid[s2_id_q] = 1'b1;
         rdata           = ram_data_read;
      end
   end

   assign gnt               = arb_gnt;
   assign init_done         = (state_q == ST_RUN);
   assign ram_write_enable  = we_q;
   assign ram_address_write = waddr_q;
   assign ram_data_write    = wdata_q;
   assign ram_address_read  = raddr_q;
   assign dbg_state_o       = state_q;

endmodule
